user_event_arbiter: RTL and testbench
=====================================

Name: user_event_arbiter

Overview:
- Merges user-event streams from several input sources (PS/2 keyboard decoder, push-button debouncer, auto-repeat generator) into the single event port of the main game logic.
- Round-robin arbitration between sources.
- Events are buffered in a small show-ahead FIFO, drained by the game logic's read-request handshake.
- EV_NEW_GAME gets special handling: flush of pending moves, plus a repeat hold-off.

Parameters:
- REQ_CNT, 3, number of event sources (2..8).
- FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2.
- HOLDOFF_CYCLES, 1024, cycles after an accepted EV_NEW_GAME during which further EV_NEW_GAME events are consumed and dropped; 0 disables the hold-off.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- src_event_i  in  REQ_CNT x 3  per-source event code (EV_* from defs.vh).
- src_valid_i  in  REQ_CNT  per-source event valid.
- src_ready_o  out  REQ_CNT  per-source accept; a transfer occurs when valid and ready are both 1.
- event_o  out  3  FIFO head event, to the game logic user_event_i.
- event_ready_o  out  1  FIFO non-empty, to the game logic user_event_ready_i.
- event_rd_req_i  in  1  pop request, from the game logic user_event_rd_req_o.
- fifo_used_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- holdoff_o  out  1  new-game hold-off active.

Behaviour:
- Reset values: src_ready_o=0, event_ready_o=0, event_o=0, fifo_used_o=0, holdoff_o=0, rr_ptr=0, hold-off counter=0. FIFO pointers are cleared.
- Reset asserted mid-operation discards all queued events immediately.
- Arbitration is combinational:
  - Grant goes to the first source i with src_valid_i[i]=1, scanning from rr_ptr upward modulo REQ_CNT.
  - src_ready_o is one-hot on the granted source, and only when accept_ok=1; otherwise it is all zero.
  - At most one transfer per cycle.
- accept_ok = (FIFO not full) OR (granted event is EV_NEW_GAME). accept_ok does not depend on event_rd_req_i, so there is no combinational path from event_rd_req_i to src_ready_o.
- On each transfer, rr_ptr <= (granted index + 1) mod REQ_CNT. Without a transfer, rr_ptr holds.
- Event classification at transfer:
  - DROP: EV_NEW_GAME while the hold-off counter != 0. The event is consumed (ready=1) but not written; FIFO and counter are unaffected.
  - FLUSH: EV_NEW_GAME while the counter == 0. The FIFO is emptied and EV_NEW_GAME becomes the sole entry (fifo_used_o=1 next cycle). A simultaneous pop in that cycle is ignored. The counter loads HOLDOFF_CYCLES.
  - PUSH: any other code. It is written at the tail; a full FIFO blocks it via accept_ok.
- Pop: when event_rd_req_i=1 and the FIFO is non-empty, the head advances on the clock edge. event_rd_req_i while empty is ignored.
- Simultaneous PUSH and pop: occupancy is unchanged, and the new entry lands behind the remaining ones.
- Show-ahead output:
  - event_o = head entry whenever event_ready_o=1; 0 when empty.
  - event_ready_o = (fifo_used_o != 0). It is registered-state derived, not from same-cycle inputs.
- Latency: an event accepted in cycle N appears at event_o in cycle N+1 if the FIFO was empty.
- Hold-off counter:
  - Width $clog2(HOLDOFF_CYCLES+1).
  - Decrements by 1 per cycle while non-zero, saturating at 0.
  - holdoff_o = (counter != 0).
  - The FLUSH reload takes priority over the decrement.
- Order: the FIFO preserves acceptance order. No reordering or coalescing.
- Pointer arithmetic: $clog2(FIFO_DEPTH)+1-bit read/write pointers with wrap bit. full = MSBs differ and LSBs equal; empty = pointers equal.

Test Plan:
- Fairness: REQ_CNT=3, all sources hold valid with EV_LEFT/EV_RIGHT/EV_DOWN, game logic pops every cycle. Required accept order: src0, src1, src2, src0, … ; event_o sequence LEFT, RIGHT, DOWN, LEFT. Each source receives exactly 1 grant per 3 transfers.
- Full back-pressure: no pops, src1 pushes 6 EV_ROTATE. Exactly 4 are accepted; src_ready_o[1]=0 with fifo_used_o=4. One pop leads to acceptance of the 5th in the next cycle; fifo_used_o stays 4.
- Flush: FIFO holds LEFT, LEFT, DOWN (used=3); src2 sends EV_NEW_GAME. Next cycle fifo_used_o=1, event_o=EV_NEW_GAME, holdoff_o=1. This holds even when the FIFO was full (used=4) at the time of the request.
- Hold-off: with HOLDOFF_CYCLES=8, a second EV_NEW_GAME 3 cycles after the first is accepted and dropped, fifo_used_o unchanged. A third EV_NEW_GAME at cycle 9 or later flushes again.
- Simultaneous push and pop at used=2: used stays 2. The popped head is the oldest entry; the new entry is last.
- Reset: assert rst_i asynchronously with used=3 and holdoff_o=1. All outputs read 0 immediately; after release the first grant goes to src0.

Source files
------------

// File: rtl/user_event_if.sv
// Event-merge bus: per-source valid/ready streams on one side,
// show-ahead FIFO read port toward the game logic on the other.
interface user_event_if #(
  parameter int REQ_CNT    = 3,
  parameter int FIFO_DEPTH = 4
);
  localparam int USED_W = $clog2(FIFO_DEPTH + 1);

  logic [REQ_CNT-1:0][2:0] src_event_i;
  logic [REQ_CNT-1:0]      src_valid_i;
  logic [REQ_CNT-1:0]      src_ready_o;
  logic [2:0]              event_o;
  logic                    event_ready_o;
  logic                    event_rd_req_i;
  logic [USED_W-1:0]       fifo_used_o;
  logic                    holdoff_o;

  modport slave (
    input  src_event_i, src_valid_i, event_rd_req_i,
    output src_ready_o, event_o, event_ready_o, fifo_used_o, holdoff_o
  );

  modport master (
    output src_event_i, src_valid_i, event_rd_req_i,
    input  src_ready_o, event_o, event_ready_o, fifo_used_o, holdoff_o
  );
endinterface

// File: rtl/user_event_arbiter.sv
// Round-robin merge of user-event sources into a show-ahead FIFO, with
// new-game flush of pending moves and a new-game repeat hold-off.
module user_event_arbiter #(
  parameter int         REQ_CNT        = 3,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         HOLDOFF_CYCLES = 1024,
  parameter logic [2:0] EV_NEW_GAME    = 3'd6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  user_event_if.slave   bus
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PW     = AW + 1;
  localparam int RRW    = $clog2(REQ_CNT);
  localparam int HW     = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int USED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  logic [RRW-1:0] r_rr_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [HW-1:0]  r_hold_cnt;
  logic [2:0]     r_mem [FIFO_DEPTH];

  logic           w_gnt_valid;
  logic [RRW-1:0] w_gnt_idx;
  logic [2:0]     w_gnt_event;
  logic           w_is_ng;
  logic           w_full;
  logic           w_empty;
  logic           w_accept_ok;
  logic           w_xfer;
  logic           w_hold_active;
  logic           w_flush;
  logic           w_push;
  logic           w_pop;

  function automatic logic [RRW-1:0] rr_index(input logic [RRW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQ_CNT) s = s - REQ_CNT;
    return RRW'(s);
  endfunction

  // First valid source at or after the round-robin pointer wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      if (!w_gnt_valid && bus.src_valid_i[rr_index(r_rr_ptr, k)]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = rr_index(r_rr_ptr, k);
      end
    end
  end

  assign w_gnt_event   = bus.src_event_i[w_gnt_idx];
  assign w_is_ng       = (w_gnt_event == EV_NEW_GAME);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  // A new-game event never waits on a full FIFO: it replaces the contents.
  assign w_accept_ok   = !w_full || w_is_ng;
  assign w_xfer        = w_gnt_valid && w_accept_ok && !rst_i;
  assign w_hold_active = (r_hold_cnt != '0);
  assign w_flush       = w_xfer && w_is_ng && !w_hold_active;
  assign w_push        = w_xfer && !w_is_ng;
  assign w_pop         = bus.event_rd_req_i && !w_empty;

  always_comb begin
    bus.src_ready_o = '0;
    if (w_xfer) bus.src_ready_o[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (w_xfer)
        r_rr_ptr <= (w_gnt_idx == RRW'(REQ_CNT - 1)) ? '0 : w_gnt_idx + RRW'(1);

      // A flush overrides any same-cycle pop.
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= PW'(1);
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end

      if (w_flush)            r_hold_cnt <= HOLD_LOAD;
      else if (w_hold_active) r_hold_cnt <= r_hold_cnt - HW'(1);
    end
  end

  // NOTE: storage is left unreset; only the pointers define validity and
  // event_o is forced to zero while empty, so stale contents never escape.
  always_ff @(posedge clk_i) begin
    if (w_flush)     r_mem[0] <= EV_NEW_GAME;
    else if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_gnt_event;
  end

  assign bus.event_o       = w_empty ? 3'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.event_ready_o = !w_empty;
  assign bus.fifo_used_o   = USED_W'(r_wr_ptr - r_rd_ptr);
  assign bus.holdoff_o     = w_hold_active;
endmodule

// File: tb/tb_user_event_arbiter.sv
// Self-checking bench for user_event_arbiter: vector table, hand-written
// flush/hold-off/reset sequences, then random traffic against a queue model.
module tb_user_event_arbiter;
  localparam int REQ_CNT = 3;
  localparam int DEPTH   = 4;
  localparam int HOLD    = 8;

  localparam logic [2:0] EV_NONE     = 3'd0;
  localparam logic [2:0] EV_LEFT     = 3'd1;
  localparam logic [2:0] EV_RIGHT    = 3'd2;
  localparam logic [2:0] EV_DOWN     = 3'd3;
  localparam logic [2:0] EV_ROTATE   = 3'd4;
  localparam logic [2:0] EV_NEW_GAME = 3'd6;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  user_event_if #(.REQ_CNT(REQ_CNT), .FIFO_DEPTH(DEPTH)) bus ();

  user_event_arbiter #(
    .REQ_CNT(REQ_CNT), .FIFO_DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD), .EV_NEW_GAME(EV_NEW_GAME)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]      valid;
    logic [2:0][2:0] ev;
    logic            rd;
    logic [2:0]      exp_ready;
    int              exp_used;
    logic [2:0]      exp_event;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input int used, input logic [2:0] ev, input logic hold);
    check({name, " used"},    32'(bus.fifo_used_o), 32'(used));
    check({name, " event"},   32'(bus.event_o), 32'(ev));
    check({name, " evready"}, 32'(bus.event_ready_o), 32'(used != 0));
    check({name, " holdoff"}, 32'(bus.holdoff_o), 32'(hold));
  endtask

  // Inputs change on the falling edge; everything is sampled 1 ns later.
  task automatic drive(input logic [2:0] v, input logic [2:0] e0, input logic [2:0] e1,
                       input logic [2:0] e2, input logic rd);
    @(negedge clk_i);
    bus.src_valid_i    = v;
    bus.src_event_i[0] = e0;
    bus.src_event_i[1] = e1;
    bus.src_event_i[2] = e2;
    bus.event_rd_req_i = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i              = 1'b1;
    bus.src_valid_i    = '0;
    bus.src_event_i    = '0;
    bus.event_rd_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Reference model state
  logic [2:0] m_q [$];
  int         m_rr;
  int         m_hold;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] rv, re0, re1, re2, exp_rdy, gev;
    logic       rrd;
    int         gi;
    bit         acc, ng, flush;

    // Fairness: all three hold valid, game logic pops every cycle.
    tbl[0]  = '{3'b111, {EV_DOWN, EV_RIGHT, EV_LEFT}, 1'b1, 3'b001, 0, EV_NONE};
    tbl[1]  = '{3'b111, {EV_DOWN, EV_RIGHT, EV_LEFT}, 1'b1, 3'b010, 1, EV_LEFT};
    tbl[2]  = '{3'b111, {EV_DOWN, EV_RIGHT, EV_LEFT}, 1'b1, 3'b100, 1, EV_RIGHT};
    tbl[3]  = '{3'b111, {EV_DOWN, EV_RIGHT, EV_LEFT}, 1'b1, 3'b001, 1, EV_DOWN};
    tbl[4]  = '{3'b111, {EV_DOWN, EV_RIGHT, EV_LEFT}, 1'b1, 3'b010, 1, EV_LEFT};
    tbl[5]  = '{3'b000, {EV_NONE, EV_NONE, EV_NONE},  1'b1, 3'b000, 1, EV_RIGHT};
    tbl[6]  = '{3'b000, {EV_NONE, EV_NONE, EV_NONE},  1'b0, 3'b000, 0, EV_NONE};
    // Back-pressure: src1 streams ROTATE with no pops until full.
    tbl[7]  = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b0, 3'b010, 0, EV_NONE};
    tbl[8]  = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b0, 3'b010, 1, EV_ROTATE};
    tbl[9]  = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b0, 3'b010, 2, EV_ROTATE};
    tbl[10] = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b0, 3'b010, 3, EV_ROTATE};
    tbl[11] = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b0, 3'b000, 4, EV_ROTATE};
    tbl[12] = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b1, 3'b000, 4, EV_ROTATE};
    tbl[13] = '{3'b010, {EV_NONE, EV_ROTATE, EV_NONE}, 1'b0, 3'b010, 3, EV_ROTATE};
    tbl[14] = '{3'b000, {EV_NONE, EV_NONE, EV_NONE},   1'b0, 3'b000, 4, EV_ROTATE};

    bus.src_valid_i    = '0;
    bus.src_event_i    = '0;
    bus.event_rd_req_i = 1'b0;
    #1;
    check("reset ready", 32'(bus.src_ready_o), 32'h0);
    chk_state("reset", 0, EV_NONE, 1'b0);
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].ev[0], tbl[i].ev[1], tbl[i].ev[2], tbl[i].rd);
      check($sformatf("vec%0d ready", i), 32'(bus.src_ready_o), 32'(tbl[i].exp_ready));
      chk_state($sformatf("vec%0d", i), tbl[i].exp_used, tbl[i].exp_event, 1'b0);
    end

    // Flush from a full FIFO, with a same-cycle pop that must be ignored.
    drive(3'b100, EV_NONE, EV_NONE, EV_NEW_GAME, 1'b1);
    check("f0 ready", 32'(bus.src_ready_o), 32'b100);
    chk_state("f0", 4, EV_ROTATE, 1'b0);
    drive(3'b000, EV_NONE, EV_NONE, EV_NONE, 1'b0);
    chk_state("f1", 1, EV_NEW_GAME, 1'b1);
    drive(3'b000, EV_NONE, EV_NONE, EV_NONE, 1'b0);
    // Second new-game 3 cycles later: consumed and dropped.
    drive(3'b001, EV_NEW_GAME, EV_NONE, EV_NONE, 1'b0);
    check("f3 drop ready", 32'(bus.src_ready_o), 32'b001);
    drive(3'b000, EV_NONE, EV_NONE, EV_NONE, 1'b0);
    chk_state("f4", 1, EV_NEW_GAME, 1'b1);
    drive(3'b010, EV_NONE, EV_LEFT, EV_NONE, 1'b1);
    check("f5 ready", 32'(bus.src_ready_o), 32'b010);
    drive(3'b100, EV_NONE, EV_NONE, EV_LEFT, 1'b0);
    chk_state("f6", 1, EV_LEFT, 1'b1);
    drive(3'b001, EV_DOWN, EV_NONE, EV_NONE, 1'b0);
    // Last hold-off cycle: still dropped.
    drive(3'b010, EV_NONE, EV_NEW_GAME, EV_NONE, 1'b0);
    check("f8 drop ready", 32'(bus.src_ready_o), 32'b010);
    chk_state("f8", 3, EV_LEFT, 1'b1);
    // Hold-off expired: flushes LEFT, LEFT, DOWN.
    drive(3'b100, EV_NONE, EV_NONE, EV_NEW_GAME, 1'b0);
    check("f9 ready", 32'(bus.src_ready_o), 32'b100);
    chk_state("f9", 3, EV_LEFT, 1'b0);
    // Simultaneous push and pop at used=2.
    drive(3'b001, EV_LEFT, EV_NONE, EV_NONE, 1'b0);
    chk_state("f10", 1, EV_NEW_GAME, 1'b1);
    drive(3'b010, EV_NONE, EV_RIGHT, EV_NONE, 1'b1);
    check("f11 ready", 32'(bus.src_ready_o), 32'b010);
    chk_state("f11", 2, EV_NEW_GAME, 1'b1);
    drive(3'b000, EV_NONE, EV_NONE, EV_NONE, 1'b1);
    chk_state("f12", 2, EV_LEFT, 1'b1);
    drive(3'b111, EV_ROTATE, EV_ROTATE, EV_ROTATE, 1'b0);
    chk_state("f13", 1, EV_RIGHT, 1'b1);
    drive(3'b111, EV_ROTATE, EV_ROTATE, EV_ROTATE, 1'b0);
    drive(3'b111, EV_ROTATE, EV_ROTATE, EV_ROTATE, 1'b0);
    chk_state("f15", 3, EV_RIGHT, 1'b1);

    // Asynchronous reset mid-operation.
    #1;
    rst_i = 1'b1;
    #1;
    check("arst ready", 32'(bus.src_ready_o), 32'h0);
    chk_state("arst", 0, EV_NONE, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("post-reset grant", 32'(bus.src_ready_o), 32'b001);

    // Random traffic against the queue model.
    do_reset();
    m_q.delete();
    m_rr   = 0;
    m_hold = 0;
    for (int c = 0; c < 2000; c++) begin
      logic [2:0] evs [3];
      for (int s = 0; s < 3; s++)
        evs[s] = ($urandom_range(0, 7) == 0) ? EV_NEW_GAME : 3'($urandom_range(1, 4));
      rv  = 3'($urandom_range(0, 7));
      rrd = 1'($urandom_range(0, 1));
      re0 = evs[0];
      re1 = evs[1];
      re2 = evs[2];
      drive(rv, re0, re1, re2, rrd);

      gi = -1;
      for (int k = 0; k < REQ_CNT; k++)
        if (gi < 0 && rv[(m_rr + k) % REQ_CNT]) gi = (m_rr + k) % REQ_CNT;
      gev     = (gi >= 0) ? evs[gi] : EV_NONE;
      ng      = (gi >= 0) && (gev == EV_NEW_GAME);
      acc     = (gi >= 0) && (m_q.size() < DEPTH || ng);
      exp_rdy = acc ? 3'(1 << gi) : 3'b000;

      check($sformatf("rnd%0d ready", c), 32'(bus.src_ready_o), 32'(exp_rdy));
      chk_state($sformatf("rnd%0d", c), m_q.size(),
                (m_q.size() > 0) ? m_q[0] : EV_NONE, m_hold != 0);

      flush = acc && ng && (m_hold == 0);
      if (acc) m_rr = (gi + 1) % REQ_CNT;
      if (flush) begin
        m_q.delete();
        m_q.push_back(EV_NEW_GAME);
      end else begin
        if (rrd && m_q.size() > 0) void'(m_q.pop_front());
        if (acc && !ng) m_q.push_back(gev);
      end
      m_hold = flush ? HOLD : ((m_hold > 0) ? m_hold - 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
